// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and accept-decode type for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic wr_ok;
    logic rd_ok;
  } accept_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// Only the read register is reset; the array itself holds no reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [ptr_width(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          re,
  input  logic [ptr_width(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Holds last read word when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with exact full/empty, occupancy count and thresholds.
// Define FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          err_clr
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  accept_t       acc;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    acc       = '0;
    acc.rd_ok = rd_en && !empty;
    acc.wr_ok = wr_en && (!full || acc.rd_ok);
  end

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (acc.wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (acc.rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({acc.wr_ok, acc.rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (acc.wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (acc.rd_ok),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky; a new rejection in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !acc.wr_ok) overflow <= 1'b1;
      else if (err_clr)        overflow <= 1'b0;
      if (rd_en && !acc.rd_ok) underflow <= 1'b1;
      else if (err_clr)        underflow <= 1'b0;
    end
  end
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at DEPTH=5, AF_THRESH=4, AE_THRESH=1.
module tb_sync_fifo_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;
  logic          err_clr;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (4),
    .AE_THRESH  (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs set beforehand are sampled at this edge; outputs observed 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"},  32'(full), 0);
    check({tag, "_af"},    32'(almost_full), 0);
    check({tag, "_ae"},    32'(almost_empty), 1);
    check({tag, "_dout"},  32'(data_out), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
    check({tag, "_udf"},   32'(underflow), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    data_in = '0;
    #12;
    check_idle_reset("reset");
    rst_n = 1'b1;
    step();

    // Fill 0x11..0x15; thresholds move with the registered count.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = DW'(8'h11 + i);
      step();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_af", 32'(almost_full), (i + 1 >= 4) ? 32'd1 : 32'd0);
      check("fill_ae", 32'(almost_empty), (i + 1 <= 1) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(full), 1);
    data_in = 8'h99;
    step();
    wr_en = 1'b0;
    check("ovf_count", 32'(count), 5);
    check("ovf_full", 32'(full), 1);
    check("ovf_flag", 32'(overflow), 32'(ERR));
    check("ovf_udf", 32'(underflow), 0);

    // Drain in order.
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      step();
      check("drain_data", 32'(data_out), 32'(8'h11 + i));
      check("drain_count", 32'(count), 32'(4 - i));
    end
    check("drain_empty", 32'(empty), 1);
    step();
    rd_en = 1'b0;
    check("udf_dout", 32'(data_out), 32'h15);
    check("udf_count", 32'(count), 0);
    check("udf_flag", 32'(underflow), 32'(ERR));
    check("udf_ovf_sticky", 32'(overflow), 32'(ERR));

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_udf", 32'(underflow), 0);

    // Write/read pairs spanning two pointer wraps.
    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1; data_in = DW'(i);
      step();
      wr_en = 1'b0;
      check("wrap_count_w", 32'(count), 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("wrap_data", 32'(data_out), 32'(i));
      check("wrap_count_r", 32'(count), 0);
    end

    // Simultaneous read and write while full.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = DW'(8'h21 + i);
      step();
    end
    check("full2_full", 32'(full), 1);
    rd_en = 1'b1; data_in = 8'hAA;
    step();
    wr_en = 1'b0;
    check("fullrw_data", 32'(data_out), 32'h21);
    check("fullrw_count", 32'(count), 5);
    check("fullrw_full", 32'(full), 1);
    check("fullrw_ovf", 32'(overflow), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("fullrw_drain", 32'(data_out), (i == 4) ? 32'hAA : 32'(8'h22 + i));
    end
    rd_en = 1'b0;
    check("fullrw_empty", 32'(empty), 1);

    // Simultaneous read and write while empty: only the write lands.
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h5C;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("emptyrw_dout", 32'(data_out), 32'hAA);
    check("emptyrw_count", 32'(count), 1);
    check("emptyrw_empty", 32'(empty), 0);
    check("emptyrw_udf", 32'(underflow), 32'(ERR));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("emptyrw_data", 32'(data_out), 32'h5C);

    // Asynchronous reset mid-burst, with overflow raised first.
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; data_in = DW'(8'h31 + i);
      step();
    end
    wr_en = 1'b0;
    check("pre_rst_ovf", 32'(overflow), 32'(ERR));
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    check("pre_rst_count", 32'(count), 3);
    check("pre_rst_dout", 32'(data_out), 32'h32);
    wr_en = 1'b1; data_in = 8'h77;
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_reset("async_rst");
    #2;
    wr_en = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_count", 32'(count), 0);
    wr_en = 1'b1; data_in = 8'h6D;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post_rst_data", 32'(data_out), 32'h6D);
    check("post_rst_empty", 32'(empty), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. Supports arbitrary (non-power-of-2) depth and exact full/empty. Adds occupancy count, programmable almost-full/almost-empty thresholds and simultaneous read/write at the full boundary. Sits between producer/consumer blocks in one clock domain.

Parameters:
DATA_WIDTH, 8, width of each data word
DEPTH, 16, number of storage entries; any integer >= 2
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
wr_en  input  1  write request
data_in  input  DATA_WIDTH  write data
rd_en  input  1  read request
data_out  output  DATA_WIDTH  registered read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: write rejected (only with FIFO_ERR_FLAGS_EN)
underflow  output  1  sticky: read rejected (only with FIFO_ERR_FLAGS_EN)
err_clr  input  1  synchronous clear of overflow/underflow

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n. Reset asserts immediately and releases synchronously with the next clk edge.
- Reset values: wr/rd pointers 0, count 0, data_out 0, empty 1, full 0, almost_full 0, almost_empty 1, overflow 0, underflow 0. Memory contents are not reset.
- Read accept: rd_ok = rd_en && !empty.
- Write accept: wr_ok = wr_en && (!full || rd_ok). When full, a write is accepted in the same cycle as an accepted read.
- Empty with rd_en and wr_en: the read is rejected, the write is accepted, and count becomes 1.
- Write: mem[wr_ptr] <= data_in on wr_ok.
- Read: data_out <= mem[rd_ptr] on rd_ok. Read latency is 1 cycle (data valid the cycle after the accepting edge). data_out holds its value when no read is accepted.
- Pointers: increment on accept; wrap from DEPTH-1 to 0. No power-of-2 assumption.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither. Never exceeds DEPTH or goes below 0.
- Flags: full, empty, almost_full, almost_empty are combinational decodes of the registered count, so they update the cycle after the change.
- Rejected operations do not modify pointers, count, memory or data_out.
- Reset mid-operation: all state returns to reset values at once. Stored data is considered lost.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined: overflow sets on wr_en && !wr_ok; underflow sets on rd_en && !rd_ok. Both are sticky until err_clr or reset. If set and clear occur in the same cycle, set wins.
- Undefined: overflow and underflow are tied 0 and err_clr is ignored. Ports remain present.

Decomposition:
- Package sync_fifo_pkg holds: function/constant for count width ($clog2(DEPTH+1)), pointer width ($clog2(DEPTH)), and a typedef for the accept-decode struct {wr_ok, rd_ok}.
- One sub-module, sync_fifo_mem: simple dual-port RAM, one write port and one registered read port, parametrised DATA_WIDTH/DEPTH.
- Top level holds pointers, count, flags and the optional error logic.

Test Plan:
- DEPTH=5: after reset write 5 words 0x11..0x15 -> count 5, full=1 on the 6th cycle. A 6th write is rejected and, with FIFO_ERR_FLAGS_EN, overflow=1.
- Continue from the full state: read 5 words -> data_out 0x11..0x15, each one cycle after its accepting edge. Then empty=1 and count 0. A further read leaves data_out=0x15, and underflow=1 with the macro.
- Wrap-around, DEPTH=5: loop 12 write/read pairs with data 0x00..0x0B -> data_out matches in order across the pointer wrap 4->0; count never exceeds 1.
- Full with simultaneous wr_en and rd_en (data_in 0xAA) -> count stays 5, full stays 1. Oldest word is output; 0xAA appears after the next 4 reads.
- Empty with simultaneous wr_en and rd_en (0x5C) -> read rejected, count 1, empty deasserts next cycle, data_out unchanged. Thresholds with AF_THRESH=4, AE_THRESH=1: almost_full rises at count 4, almost_empty falls at count 2.
- Pulse rst_n low asynchronously mid-burst at count 3 -> all outputs immediately at reset values without a clk edge. err_clr with overflow=1 -> 0 on the next edge.
